mips_main_ctrl_fsm: RTL and testbench
=====================================

// Module: mips_main_ctrl_fsm
// PURPOSE
//  Main control state machine of the multi-cycle MIPS datapath. Decodes the IR opcode and steps each
//  instruction through fetch/decode/execute/memory/writeback states. Drives the select inputs of the
//  datapath mux2/mux4 instances (IorD, ALUSrcA, ALUSrcB, MemtoReg, RegDst, PCSrc) and all write enables.
//  Sits between the instruction register and the datapath. The ALU decoder consumes its alu_op output.
// PARAMETERS
//  OPW     6   opcode width (IR[31:26])
//  STATEW  4   state register width (12 states used)
// PORTS
//  clk          in   1       single clock; all state updates on rising edge
//  reset        in   1       asynchronous, active-high reset
//  opcode       in   OPW     IR[31:26], valid from the DECODE state onward
//  mem_ready    in   1       memory handshake; 1 = current access completes this cycle
//  pc_write     out  1       unconditional PC write enable
//  branch       out  1       conditional PC write; datapath ANDs it with ALU zero
//  iord         out  1       mux2 select: 0 = PC, 1 = ALUOut as memory address
//  mem_write    out  1       memory write strobe
//  ir_write     out  1       instruction register load enable
//  reg_write    out  1       register file write enable
//  reg_dst      out  1       mux2 select: 0 = rt, 1 = rd
//  mem_to_reg   out  1       mux2 select: 0 = ALUOut, 1 = MDR
//  alu_src_a    out  1       mux2 select: 0 = PC, 1 = A
//  alu_src_b    out  2       mux4 select: 00 = B, 01 = const 4, 10 = signext imm, 11 = signext imm<<2
//  pc_src       out  2       mux4 select: 00 = ALU result, 01 = ALUOut, 10 = jump target
//  alu_op       out  2       00 = add, 01 = sub, 10 = decode funct
//  illegal_op   out  1       one-cycle pulse when DECODE sees an unsupported opcode
//  state_dbg    out  STATEW  current state, for debug and the testbench
// BEHAVIOUR
//  - reset high: the state is FETCH immediately, asynchronously. While reset is high, every output is 0
//    except state_dbg. Reset mid-instruction discards that instruction and asserts no further write enables.
//  - Outputs are Moore. They are decoded combinationally from the state only. The only exceptions are the
//    mem_ready gating of pc_write/ir_write and the illegal_op pulse.
//  - Unlisted outputs in a state are 0. Supported opcodes: R=000000, LW=100011, SW=101011, BEQ=000100,
//    ADDI=001000, J=000010.
//  - States, their outputs, and next state:
//    FETCH    iord=0 src_a=0 src_b=01 op=00 pc_src=00; ir_write=pc_write=mem_ready
//             -> DECODE if mem_ready, else hold
//    DECODE   src_a=0 src_b=11 op=00
//             -> LW/SW: MEMADR; R: EXECUTE; BEQ: BRANCH; ADDI: ADDIEX; J: JUMP;
//                other: FETCH with illegal_op=1 for this cycle
//    MEMADR   src_a=1 src_b=10 op=00 -> MEMRD if LW, MEMWR if SW
//    MEMRD    iord=1 -> MEMWB if mem_ready, else hold
//    MEMWB    reg_dst=0 mem_to_reg=1 reg_write=1 -> FETCH
//    MEMWR    iord=1 mem_write=1 (held until mem_ready) -> FETCH if mem_ready, else hold
//    EXECUTE  src_a=1 src_b=00 op=10 -> ALUWB
//    ALUWB    reg_dst=1 mem_to_reg=0 reg_write=1 -> FETCH
//    BRANCH   src_a=1 src_b=00 op=01 pc_src=01 branch=1 -> FETCH
//    ADDIEX   src_a=1 src_b=10 op=00 -> ADDIWB
//    ADDIWB   reg_dst=0 mem_to_reg=0 reg_write=1 -> FETCH
//    JUMP     pc_src=10 pc_write=1 -> FETCH
//  - Latency with mem_ready tied to 1: LW 5 cycles; R, SW and ADDI 4; BEQ and J 3; illegal opcode 2.
//    Each FETCH/MEMRD/MEMWR stall cycle adds exactly 1 cycle.
//  - pc_write is asserted at most once per FETCH, however long the stall lasts. The PC never
//    double-increments.
//  - opcode is sampled only in DECODE and MEMADR. Changes in other states have no effect.
//  - Unused state encodings: next state is FETCH and all outputs are 0.
// STRUCTURE
//  - Shared package mips_ctrl_pkg holds:
//    state enum (FETCH=0, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP);
//    opcode constants; ALUOP_ADD/SUB/FUNCT; SRCB_* and PCSRC_* select encodings.
//  - Single module. Three processes: state register, next-state logic, output decode.
//  - No sub-module. The funct-level ALU decoder remains a separate existing block.
// TESTING
//  1. reset=1 mid-MEMWB: all outputs 0 at once and state_dbg=0. After release, first cycle has
//     pc_write=ir_write=1 and src_b=01.
//  2. LW (100011), mem_ready=1: states 0,1,2,3,4 over 5 cycles. reg_write=1 and mem_to_reg=1 only in
//     cycle 5; back to FETCH in cycle 6.
//  3. SW with mem_ready=0 for 3 cycles in MEMWR: mem_write held high for 4 cycles, no reg_write,
//     then FETCH.
//  4. FETCH with mem_ready low for 2 cycles: pc_write and ir_write stay 0 until the ready cycle,
//     pulse exactly once, then DECODE.
//  5. BEQ -> BRANCH (branch=1, pc_src=01, alu_op=01); J -> JUMP (pc_write=1, pc_src=10);
//     each completes in 3 cycles.
//  6. opcode=111111 in DECODE: illegal_op=1 for one cycle, next state FETCH,
//     no write enable asserted in that cycle.

Source files
------------

// File: rtl/mips_main_ctrl_fsm_pkg.sv
// Shared types and encodings for the multi-cycle MIPS main control FSM.
// Holds the state enum, opcode constants and the datapath select encodings.
package mips_ctrl_pkg;

  localparam int OPW    = 6;
  localparam int STATEW = 4;

  typedef enum logic [STATEW-1:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } state_t;

  localparam logic [OPW-1:0] OP_R    = 6'b000000;
  localparam logic [OPW-1:0] OP_LW   = 6'b100011;
  localparam logic [OPW-1:0] OP_SW   = 6'b101011;
  localparam logic [OPW-1:0] OP_BEQ  = 6'b000100;
  localparam logic [OPW-1:0] OP_ADDI = 6'b001000;
  localparam logic [OPW-1:0] OP_J    = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_main_ctrl_fsm_if.sv
// Control bundle between the main control FSM (master) and the datapath (slave).
interface mips_main_ctrl_fsm_if;
  import mips_ctrl_pkg::*;

  logic [OPW-1:0]    opcode;
  logic              mem_ready;
  logic              pc_write;
  logic              branch;
  logic              iord;
  logic              mem_write;
  logic              ir_write;
  logic              reg_write;
  logic              reg_dst;
  logic              mem_to_reg;
  logic              alu_src_a;
  logic [1:0]        alu_src_b;
  logic [1:0]        pc_src;
  logic [1:0]        alu_op;
  logic              illegal_op;
  logic [STATEW-1:0] state_dbg;

  modport master (
    input  opcode, mem_ready,
    output pc_write, branch, iord, mem_write, ir_write, reg_write, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, pc_src, alu_op, illegal_op, state_dbg
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, branch, iord, mem_write, ir_write, reg_write, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, pc_src, alu_op, illegal_op, state_dbg
  );

endinterface

// File: rtl/mips_main_ctrl_fsm.sv
// Main control FSM of the multi-cycle MIPS datapath: Moore decode of the state,
// with mem_ready gating the fetch write enables and a one-cycle illegal_op pulse.
module mips_main_ctrl_fsm
  import mips_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  mips_main_ctrl_fsm_if.master  bus
);

  state_t state_reg;
  state_t state_next;

  logic       pc_write;
  logic       branch;
  logic       iord;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_src;
  logic [1:0] alu_op;
  logic       illegal_op;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = FETCH;
    case (state_reg)
      FETCH:   state_next = bus.mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_R:         state_next = EXECUTE;
          OP_BEQ:       state_next = BRANCH;
          OP_ADDI:      state_next = ADDIEX;
          OP_J:         state_next = JUMP;
          default:      state_next = FETCH;
        endcase
      end
      // Opcode is re-sampled here to pick the access direction.
      MEMADR: begin
        if (bus.opcode == OP_LW)      state_next = MEMRD;
        else if (bus.opcode == OP_SW) state_next = MEMWR;
        else                          state_next = FETCH;
      end
      MEMRD:   state_next = bus.mem_ready ? MEMWB : MEMRD;
      MEMWB:   state_next = FETCH;
      MEMWR:   state_next = bus.mem_ready ? FETCH : MEMWR;
      EXECUTE: state_next = ALUWB;
      ALUWB:   state_next = FETCH;
      BRANCH:  state_next = FETCH;
      ADDIEX:  state_next = ADDIWB;
      ADDIWB:  state_next = FETCH;
      JUMP:    state_next = FETCH;
      default: state_next = FETCH;
    endcase
  end

  // Reset forces every control low so an aborted instruction cannot write anything.
  always_comb begin
    pc_write   = 1'b0;
    branch     = 1'b0;
    iord       = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_B;
    pc_src     = PCSRC_ALU;
    alu_op     = ALUOP_ADD;
    illegal_op = 1'b0;
    if (!reset) begin
      case (state_reg)
        FETCH: begin
          alu_src_b = SRCB_FOUR;
          pc_write  = bus.mem_ready;
          ir_write  = bus.mem_ready;
        end
        DECODE: begin
          alu_src_b = SRCB_IMM_SH2;
          case (bus.opcode)
            OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: illegal_op = 1'b0;
            default:                                   illegal_op = 1'b1;
          endcase
        end
        MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        MEMRD: iord = 1'b1;
        MEMWB: begin
          mem_to_reg = 1'b1;
          reg_write  = 1'b1;
        end
        MEMWR: begin
          iord      = 1'b1;
          mem_write = 1'b1;
        end
        EXECUTE: begin
          alu_src_a = 1'b1;
          alu_op    = ALUOP_FUNCT;
        end
        ALUWB: begin
          reg_dst   = 1'b1;
          reg_write = 1'b1;
        end
        BRANCH: begin
          alu_src_a = 1'b1;
          alu_op    = ALUOP_SUB;
          pc_src    = PCSRC_ALUOUT;
          branch    = 1'b1;
        end
        ADDIEX: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        ADDIWB: reg_write = 1'b1;
        JUMP: begin
          pc_src   = PCSRC_JUMP;
          pc_write = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.pc_write   = pc_write;
  assign bus.branch     = branch;
  assign bus.iord       = iord;
  assign bus.mem_write  = mem_write;
  assign bus.ir_write   = ir_write;
  assign bus.reg_write  = reg_write;
  assign bus.reg_dst    = reg_dst;
  assign bus.mem_to_reg = mem_to_reg;
  assign bus.alu_src_a  = alu_src_a;
  assign bus.alu_src_b  = alu_src_b;
  assign bus.pc_src     = pc_src;
  assign bus.alu_op     = alu_op;
  assign bus.illegal_op = illegal_op;
  assign bus.state_dbg  = state_reg;

endmodule

// File: tb/tb_mips_main_ctrl_fsm.sv
// Scoreboard bench for the main control FSM: the driver queues the expected
// per-cycle state and controls, a negedge monitor pops and compares them.
module tb_mips_main_ctrl_fsm;

  typedef struct packed {
    logic [3:0] st;
    logic       pw, br, iord, mw, irw, rw, rd, m2r, sa;
    logic [1:0] sb, ps, op;
    logic       ill;
  } exp_t;

  typedef struct {
    exp_t  e;
    string tag;
  } item_t;

  localparam logic [5:0] R    = 6'b000000;
  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] J    = 6'b000010;
  localparam logic [5:0] BAD  = 6'b111111;

  logic clk = 1'b0;
  logic reset = 1'b1;

  item_t q[$];
  int    checks = 0;
  int    errors = 0;
  bit    done = 1'b0;

  mips_main_ctrl_fsm_if bus();

  mips_main_ctrl_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Expected outputs of each state, written straight from the state table.
  function automatic exp_t want(input logic [3:0] st, input logic rdy, input logic ill);
    exp_t e;
    e = '0;
    e.st = st;
    case (st)
      4'd0:  begin e.sb = 2'b01; e.pw = rdy; e.irw = rdy; end
      4'd1:  begin e.sb = 2'b11; e.ill = ill; end
      4'd2:  begin e.sa = 1'b1; e.sb = 2'b10; end
      4'd3:  e.iord = 1'b1;
      4'd4:  begin e.m2r = 1'b1; e.rw = 1'b1; end
      4'd5:  begin e.iord = 1'b1; e.mw = 1'b1; end
      4'd6:  begin e.sa = 1'b1; e.op = 2'b10; end
      4'd7:  begin e.rd = 1'b1; e.rw = 1'b1; end
      4'd8:  begin e.sa = 1'b1; e.op = 2'b01; e.ps = 2'b01; e.br = 1'b1; end
      4'd9:  begin e.sa = 1'b1; e.sb = 2'b10; end
      4'd10: e.rw = 1'b1;
      4'd11: begin e.ps = 2'b10; e.pw = 1'b1; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic cyc(input logic r, input logic [5:0] opc, input logic rdy,
                     input logic [3:0] st, input logic ill, input string tag);
    item_t it;
    @(posedge clk);
    #1;
    reset = r;
    bus.opcode = opc;
    bus.mem_ready = rdy;
    if (r) begin
      it.e = '0;
    end else begin
      it.e = want(st, rdy, ill);
    end
    it.tag = tag;
    q.push_back(it);
  endtask

  initial begin : monitor
    item_t it;
    exp_t  act;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        it = q.pop_front();
        act.st  = bus.state_dbg;
        act.pw  = bus.pc_write;
        act.br  = bus.branch;
        act.iord = bus.iord;
        act.mw  = bus.mem_write;
        act.irw = bus.ir_write;
        act.rw  = bus.reg_write;
        act.rd  = bus.reg_dst;
        act.m2r = bus.mem_to_reg;
        act.sa  = bus.alu_src_a;
        act.sb  = bus.alu_src_b;
        act.ps  = bus.pc_src;
        act.op  = bus.alu_op;
        act.ill = bus.illegal_op;
        checks++;
        if (act !== it.e) begin
          errors++;
          $display("FAIL %s got st=%0d ctl=%b required st=%0d ctl=%b",
                   it.tag, act.st, act[15:0], it.e.st, it.e[15:0]);
        end else begin
          $display("ok   %s st=%0d ctl=%b", it.tag, act.st, act[15:0]);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    if (!done) begin
      $display("FAIL watchdog got timeout required completion");
      $fatal(1, "bench timeout");
    end
  end

  initial begin : driver
    bus.opcode = 6'b0;
    bus.mem_ready = 1'b1;

    cyc(1, J,  1, 0, 0, "reset_hold0");
    cyc(1, J,  1, 0, 0, "reset_hold1");

    // LW, mem_ready tied high: 0,1,2,3,4 then FETCH
    cyc(0, J,  1, 0, 0, "lw_fetch");
    cyc(0, LW, 1, 1, 0, "lw_decode");
    cyc(0, LW, 1, 2, 0, "lw_memadr");
    cyc(0, LW, 1, 3, 0, "lw_memrd");
    cyc(0, LW, 1, 4, 0, "lw_memwb");
    cyc(0, J,  1, 0, 0, "lw_back_fetch");

    // Reset asserted while in MEMWB discards the write-back
    cyc(0, LW, 1, 1, 0, "rst_decode");
    cyc(0, LW, 1, 2, 0, "rst_memadr");
    cyc(0, LW, 1, 3, 0, "rst_memrd");
    cyc(1, LW, 1, 0, 0, "rst_mid_memwb");
    cyc(1, LW, 1, 0, 0, "rst_held");
    cyc(0, SW, 1, 0, 0, "rst_release_fetch");

    // SW with three MEMWR stall cycles
    cyc(0, SW, 1, 1, 0, "sw_decode");
    cyc(0, SW, 1, 2, 0, "sw_memadr");
    cyc(0, SW, 0, 5, 0, "sw_memwr_stall0");
    cyc(0, SW, 0, 5, 0, "sw_memwr_stall1");
    cyc(0, SW, 0, 5, 0, "sw_memwr_stall2");
    cyc(0, SW, 1, 5, 0, "sw_memwr_ready");

    // FETCH stall of two cycles, then an R-type
    cyc(0, R,  0, 0, 0, "fetch_stall0");
    cyc(0, R,  0, 0, 0, "fetch_stall1");
    cyc(0, R,  1, 0, 0, "fetch_ready");
    cyc(0, R,  1, 1, 0, "r_decode");
    cyc(0, R,  1, 6, 0, "r_execute");
    cyc(0, R,  1, 7, 0, "r_aluwb");

    // BEQ and J, three cycles each
    cyc(0, BEQ, 1, 0, 0, "beq_fetch");
    cyc(0, BEQ, 1, 1, 0, "beq_decode");
    cyc(0, BEQ, 1, 8, 0, "beq_branch");
    cyc(0, J,   1, 0, 0, "j_fetch");
    cyc(0, J,   1, 1, 0, "j_decode");
    cyc(0, J,   1, 11, 0, "j_jump");

    // ADDI
    cyc(0, ADDI, 1, 0, 0, "addi_fetch");
    cyc(0, ADDI, 1, 1, 0, "addi_decode");
    cyc(0, ADDI, 1, 9, 0, "addi_ex");
    cyc(0, ADDI, 1, 10, 0, "addi_wb");

    // Illegal opcode: pulse for one cycle then FETCH
    cyc(0, BAD, 1, 0, 0, "bad_fetch");
    cyc(0, BAD, 1, 1, 1, "bad_decode");
    cyc(0, BAD, 1, 0, 0, "bad_back_fetch");

    // LW with a MEMRD stall while opcode changes; the change must be ignored
    cyc(0, LW, 1, 1, 0, "lw2_decode");
    cyc(0, LW, 1, 2, 0, "lw2_memadr");
    cyc(0, J,  0, 3, 0, "lw2_memrd_stall");
    cyc(0, SW, 1, 3, 0, "lw2_memrd_ready");
    cyc(0, BAD, 1, 4, 0, "lw2_memwb");
    cyc(0, R,  0, 0, 0, "lw2_back_fetch");

    for (int i = 0; i < 20 && q.size() > 0; i++) begin
      @(negedge clk);
    end
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending required 0", q.size());
    end
    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
